// File: rtl/fft_bin_streamer.sv
// fft_bin_streamer: captures a complete parallel FFT frame in one cycle, then streams it out
// one bin per cycle over valid/ready with index and last markers (optionally bit-reversed order).
`timescale 1ns/1ps
module fft_bin_streamer #(
   parameter int N_BINS  = 32,
   parameter int W       = 16,
   parameter int BIT_REV = 0,
   localparam int IW     = $clog2(N_BINS)
) (
   input  logic                    clk_100,
   input  logic                    reset,
   input  logic                    frame_valid,
   output logic                    frame_ready,
   input  logic [N_BINS*2*W-1:0]   bins_in,
   output logic                    bin_valid,
   input  logic                    bin_ready,
   output logic [2*W-1:0]          bin_data,
   output logic [IW-1:0]           bin_index,
   output logic                    bin_last,
   output logic                    frame_drop,
   output logic [7:0]              drop_count
);

   typedef enum logic {S_IDLE, S_STREAM} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [IW-1:0]   rd_idx;
   logic [2*W-1:0]  bins_q [N_BINS];
   logic [2*W-1:0]  bins_d [N_BINS];
   logic            frame_drop_q, frame_drop_d;
   logic [7:0]      drop_count_q, drop_count_d;
   logic            fire;
   logic            capture;

   function automatic logic [IW-1:0] bit_reverse(input logic [IW-1:0] v);
      logic [IW-1:0] r;
      for (int b = 0; b < IW; b++) r[b] = v[IW-1-b];
      return r;
   endfunction

   // State register
   always_ff @(posedge clk_100 or posedge reset) begin
      // NOTE: flops use <= so every register samples the pre-edge values of its inputs.
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; a last beat accepted alongside a new frame keeps streaming with no bubble
   always_comb begin
      // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (capture) state_d = S_STREAM;
         S_STREAM: if (fire && bin_last && !frame_valid) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Output logic; frame_ready is combinational through bin_ready
   always_comb begin
      bin_valid   = (state_q == S_STREAM);
      bin_index   = idx_q;
      bin_last    = bin_valid && (idx_q == IW'(N_BINS - 1));
      rd_idx      = (BIT_REV != 0) ? bit_reverse(idx_q) : idx_q;
      bin_data    = bins_q[rd_idx];
      fire        = bin_valid & bin_ready;
      frame_ready = (state_q == S_IDLE) | (fire & bin_last);
      capture     = frame_valid & frame_ready;
   end

   // Datapath: the buffer is only written on capture, so a refused frame never touches it
   always_comb begin
      idx_d  = idx_q;
      bins_d = bins_q;
      if (capture) begin
         idx_d = '0;
         for (int k = 0; k < N_BINS; k++) bins_d[k] = bins_in[k*2*W +: 2*W];
      end else if (fire) begin
         idx_d = bin_last ? '0 : idx_q + IW'(1);
      end
   end

   always_comb begin
      frame_drop_d = frame_valid & ~frame_ready;
      drop_count_d = drop_count_q;
      if (frame_drop_d && (drop_count_q != 8'hFF)) drop_count_d = drop_count_q + 8'd1;
   end

   always_ff @(posedge clk_100 or posedge reset) begin
      if (reset) begin
         // NOTE: the frame buffer is reset so bin_data reads 0 after reset; costs a reset net per bit.
         for (int k = 0; k < N_BINS; k++) bins_q[k] <= '0;
         idx_q        <= '0;
         frame_drop_q <= 1'b0;
         drop_count_q <= 8'd0;
      end else begin
         bins_q       <= bins_d;
         idx_q        <= idx_d;
         frame_drop_q <= frame_drop_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign frame_drop = frame_drop_q;
   assign drop_count = drop_count_q;

endmodule

// File: tb/tb_fft_bin_streamer.sv
// Self-checking bench for fft_bin_streamer: natural and bit-reversed instances share stimulus and
// are compared each cycle against a queue-based frame/beat model, plus a ramp-frame vector table.
`timescale 1ns/1ps
module tb_fft_bin_streamer;
   localparam int N = 32;
   localparam int W = 16;

   logic              clk_100 = 1'b0;
   logic              reset;
   logic              frame_valid;
   logic              bin_ready;
   logic [N*2*W-1:0]  bins_in;
   logic              fr_n, fr_r, bv_n, bv_r, bl_n, bl_r, fd_n, fd_r;
   logic [2*W-1:0]    bd_n, bd_r;
   logic [4:0]        bi_n, bi_r;
   logic [7:0]        dc_n, dc_r;

   always #5 clk_100 = ~clk_100;

   fft_bin_streamer #(.N_BINS(N), .W(W), .BIT_REV(0)) u_nat (
      .clk_100(clk_100), .reset(reset), .frame_valid(frame_valid), .frame_ready(fr_n),
      .bins_in(bins_in), .bin_valid(bv_n), .bin_ready(bin_ready), .bin_data(bd_n),
      .bin_index(bi_n), .bin_last(bl_n), .frame_drop(fd_n), .drop_count(dc_n));

   fft_bin_streamer #(.N_BINS(N), .W(W), .BIT_REV(1)) u_rev (
      .clk_100(clk_100), .reset(reset), .frame_valid(frame_valid), .frame_ready(fr_r),
      .bins_in(bins_in), .bin_valid(bv_r), .bin_ready(bin_ready), .bin_data(bd_r),
      .bin_index(bi_r), .bin_last(bl_r), .frame_drop(fd_r), .drop_count(dc_r));

   // Reference model: a queue of beats still owed to the consumer
   typedef struct {
      logic [31:0] dn;
      logic [31:0] dr;
      int          idx;
   } beat_t;

   typedef struct {
      int          beat;
      logic [31:0] exp_nat;
      logic [31:0] exp_rev;
      logic        exp_last;
   } vec_t;

   beat_t       exp_q[$];
   int          m_drop_count;
   bit          m_drop_pending;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] obs_dn[$];
   logic [31:0] obs_dr[$];
   logic        obs_last[$];
   int          vrun, max_run;
   vec_t        tbl[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int rev5(input int i);
      int r = 0;
      int v = i;
      for (int b = 0; b < 5; b++) begin
         r = r * 2 + v % 2;
         v = v / 2;
      end
      return r;
   endfunction

   task automatic ramp_frame();
      for (int k = 0; k < N; k++) bins_in[k*2*W +: 2*W] = {16'(k), 16'h8000 | 16'(k)};
   endtask

   task automatic random_frame();
      for (int k = 0; k < N; k++) bins_in[k*2*W +: 2*W] = $urandom;
   endtask

   // One clock: compare outputs mid-cycle against the model, then advance the model
   task automatic cycle();
      bit ready_exp;
      @(negedge clk_100);
      ready_exp = (exp_q.size() == 0) || (exp_q.size() == 1 && bin_ready);
      check("valid_nat", 64'(bv_n), 64'(exp_q.size() > 0));
      check("valid_rev", 64'(bv_r), 64'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
         check("data_nat",  64'(bd_n), 64'(exp_q[0].dn));
         check("data_rev",  64'(bd_r), 64'(exp_q[0].dr));
         check("index_nat", 64'(bi_n), 64'(exp_q[0].idx));
         check("index_rev", 64'(bi_r), 64'(exp_q[0].idx));
         check("last_nat",  64'(bl_n), 64'(exp_q[0].idx == N - 1));
         check("last_rev",  64'(bl_r), 64'(exp_q[0].idx == N - 1));
      end else begin
         check("last_idle", 64'({bl_n, bl_r}), 64'(0));
      end
      check("frame_ready", 64'({fr_n, fr_r}), ready_exp ? 64'(3) : 64'(0));
      check("frame_drop",  64'({fd_n, fd_r}), m_drop_pending ? 64'(3) : 64'(0));
      check("drop_count_nat", 64'(dc_n), 64'(m_drop_count));
      check("drop_count_rev", 64'(dc_r), 64'(m_drop_count));
      if (bv_n) begin
         vrun++;
         if (vrun > max_run) max_run = vrun;
      end else begin
         vrun = 0;
      end
      if (bv_n && bin_ready) begin
         obs_dn.push_back(bd_n);
         obs_dr.push_back(bd_r);
         obs_last.push_back(bl_n);
      end
      if (exp_q.size() > 0 && bin_ready) void'(exp_q.pop_front());
      m_drop_pending = frame_valid && !ready_exp;
      if (m_drop_pending && m_drop_count < 255) m_drop_count++;
      if (frame_valid && ready_exp) begin
         for (int i = 0; i < N; i++) begin
            beat_t b;
            b.dn  = bins_in[i*2*W +: 2*W];
            b.dr  = bins_in[rev5(i)*2*W +: 2*W];
            b.idx = i;
            exp_q.push_back(b);
         end
      end
      @(posedge clk_100);
      #1;
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      frame_valid = 1'b0;
      bin_ready   = 1'b0;
      exp_q.delete();
      m_drop_count   = 0;
      m_drop_pending = 1'b0;
      repeat (3) @(posedge clk_100);
      @(negedge clk_100);
      check("rst_bin_valid",   64'({bv_n, bv_r}), 64'(0));
      check("rst_frame_ready", 64'({fr_n, fr_r}), 64'(3));
      check("rst_drop_count",  64'({dc_n, dc_r}), 64'(0));
      check("rst_bin_data",    64'({bd_n, bd_r}), 64'(0));
      check("rst_frame_drop",  64'({fd_n, fd_r}), 64'(0));
      check("rst_bin_index",   64'({bi_n, bi_r, bl_n, bl_r}), 64'(0));
      @(posedge clk_100);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int budget;
      reset       = 1'b1;
      frame_valid = 1'b0;
      bin_ready   = 1'b0;
      bins_in     = '0;

      tbl[0] = '{0,  32'h0000_8000, 32'h0000_8000, 1'b0};
      tbl[1] = '{1,  32'h0001_8001, 32'h0010_8010, 1'b0};
      tbl[2] = '{2,  32'h0002_8002, 32'h0008_8008, 1'b0};
      tbl[3] = '{3,  32'h0003_8003, 32'h0018_8018, 1'b0};
      tbl[4] = '{30, 32'h001E_801E, 32'h000F_800F, 1'b0};
      tbl[5] = '{31, 32'h001F_801F, 32'h001F_801F, 1'b1};

      do_reset();

      // Ramp frame, no backpressure: latency 1, 32 beats, then idle
      ramp_frame();
      obs_dn.delete(); obs_dr.delete(); obs_last.delete();
      frame_valid = 1'b1;
      bin_ready   = 1'b1;
      cycle();
      frame_valid = 1'b0;
      repeat (33) cycle();
      check("ramp_beats", 64'(obs_dn.size()), 64'(32));
      if (obs_dn.size() == 32) begin
         for (int t = 0; t < 6; t++) begin
            check($sformatf("tbl_nat_beat%0d", tbl[t].beat), 64'(obs_dn[tbl[t].beat]), 64'(tbl[t].exp_nat));
            check($sformatf("tbl_rev_beat%0d", tbl[t].beat), 64'(obs_dr[tbl[t].beat]), 64'(tbl[t].exp_rev));
            check($sformatf("tbl_last_beat%0d", tbl[t].beat), 64'(obs_last[tbl[t].beat]), 64'(tbl[t].exp_last));
         end
      end

      // Random 50% backpressure on a random frame
      random_frame();
      obs_dn.delete(); obs_dr.delete(); obs_last.delete();
      frame_valid = 1'b1;
      bin_ready   = 1'($urandom_range(0, 1));
      cycle();
      frame_valid = 1'b0;
      budget = 0;
      while (exp_q.size() > 0 && budget < 400) begin
         bin_ready = 1'($urandom_range(0, 1));
         cycle();
         budget++;
      end
      check("bp_drained", 64'(exp_q.size()), 64'(0));
      check("bp_beats", 64'(obs_dn.size()), 64'(32));

      // Back-to-back: frame_valid held high through frame A, frame B follows with no bubble
      do_reset();
      random_frame();
      frame_valid = 1'b1;
      bin_ready   = 1'b1;
      vrun = 0;
      max_run = 0;
      cycle();
      random_frame();
      for (int i = 0; i < 32; i++) cycle();
      frame_valid = 1'b0;
      repeat (33) cycle();
      check("b2b_valid_run", 64'(max_run), 64'(64));
      check("b2b_drops", 64'(dc_n), 64'(31));

      // Drop during a stalled beat 10, then reset at beat 20
      do_reset();
      random_frame();
      frame_valid = 1'b1;
      bin_ready   = 1'b1;
      cycle();
      frame_valid = 1'b0;
      budget = 0;
      while (exp_q.size() > 0 && exp_q[0].idx < 10 && budget < 200) begin
         bin_ready = 1'($urandom_range(0, 1));
         cycle();
         budget++;
      end
      check("at_beat10", 64'(bi_n), 64'(10));
      bin_ready   = 1'b0;
      frame_valid = 1'b1;
      random_frame();
      cycle();
      frame_valid = 1'b0;
      check("drop_pulse", 64'({fd_n, fd_r}), 64'(3));
      check("drop_count_one", 64'(dc_n), 64'(1));
      check("stall_index_held", 64'(bi_n), 64'(10));
      budget = 0;
      while (exp_q.size() > 0 && exp_q[0].idx < 20 && budget < 200) begin
         bin_ready = 1'($urandom_range(0, 1));
         cycle();
         budget++;
      end
      check("at_beat20", 64'(bi_n), 64'(20));
      reset = 1'b1;
      #1;
      check("midreset_valid", 64'({bv_n, bv_r}), 64'(0));
      check("midreset_ready", 64'({fr_n, fr_r}), 64'(3));
      do_reset();

      // First frame after reset starts at index 0
      ramp_frame();
      frame_valid = 1'b1;
      bin_ready   = 1'b1;
      cycle();
      frame_valid = 1'b0;
      check("post_reset_index0", 64'(bi_n), 64'(0));
      repeat (33) cycle();
      check("post_reset_drained", 64'(exp_q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
